// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: clock set-mode FSM with held-button auto-repeat; define SETMODE_TIMEOUT_EN for idle return to RUN
module set_mode_ctrl #(
  parameter int HOLD_CYC = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       adv_btn,
  input  logic       alarm_btn,
  output logic       timeset,
  output logic       alarmset,
  output logic       minadv,
  output logic       hrsadv,
  output logic       dayadv,
  output logic       datadv,
  output logic       monadv,
  output logic       alarmon,
  output logic [3:0] mode
);
  typedef enum logic [3:0] {
    RUN   = 4'd0,
    T_MIN = 4'd1,
    T_HRS = 4'd2,
    T_DAY = 4'd3,
    T_DAT = 4'd4,
    T_MON = 4'd5,
    A_MIN = 4'd6,
    A_HRS = 4'd7,
    A_DAY = 4'd8
  } state_t;
  state_t state, cur, step, nxt;
  logic mode_prev, alarm_prev, mode_edge, alarm_edge, tmo, chg, go;
  logic [3:0] hold, hold_nxt;
  logic [4:0] fsel, stb;
`ifdef SETMODE_TIMEOUT_EN
  logic [7:0] idle;
`endif
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_hold_chk
    $error("HOLD_CYC out of range 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_tmo_chk
    $error("TIMEOUT_CYC out of range 1..255");
  end
  always_comb begin
    mode_edge = mode_btn & ~mode_prev;
    alarm_edge = alarm_btn & ~alarm_prev;
    cur = (state > A_DAY) ? RUN : state;
    step = (cur == A_DAY) ? RUN : state_t'(cur + 4'd1);
`ifdef SETMODE_TIMEOUT_EN
    tmo = (idle == 8'(TIMEOUT_CYC));
`else
    tmo = 1'b0;
`endif
    nxt = tmo ? RUN : mode_edge ? step : cur;
    chg = (nxt != state);
    go = adv_btn & (hold == 4'd0 || hold >= 4'(HOLD_CYC)) & ~mode_edge & ~tmo;
    fsel = (cur == T_MIN || cur == A_MIN) ? 5'b00001 :
           (cur == T_HRS || cur == A_HRS) ? 5'b00010 :
           (cur == T_DAY || cur == A_DAY) ? 5'b00100 :
           (cur == T_DAT)                 ? 5'b01000 :
           (cur == T_MON)                 ? 5'b10000 : 5'b00000;
    hold_nxt = (adv_btn & ~chg) ? hold + {3'd0, hold != 4'hf} : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      timeset <= 1'b0;
      alarmset <= 1'b0;
      stb <= 5'd0;
      alarmon <= 1'b0;
      mode_prev <= 1'b0;
      alarm_prev <= 1'b0;
      hold <= 4'd0;
    end else begin
      state <= nxt;
      timeset <= nxt inside {[T_MIN:T_MON]};
      alarmset <= nxt inside {[A_MIN:A_DAY]};
      stb <= go ? fsel : 5'd0;
      alarmon <= alarmon ^ alarm_edge;
      mode_prev <= mode_btn;
      alarm_prev <= alarm_btn;
      hold <= hold_nxt;
    end
  end
`ifdef SETMODE_TIMEOUT_EN
  always_ff @(posedge clk)
    idle <= (rst || mode_edge || adv_btn || cur == RUN) ? 8'd0 : idle + 8'd1;
`endif
  assign mode = state;
  assign {monadv, datadv, dayadv, hrsadv, minadv} = stb;
endmodule

// File: tb/tb_set_mode_ctrl.sv
// tb_set_mode_ctrl: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_set_mode_ctrl;
  localparam int HOLD = 3;
  localparam int TMO = 15;
  logic clk = 0, rst = 1, mode_btn = 0, adv_btn = 0, alarm_btn = 0;
  logic timeset, alarmset, minadv, hrsadv, dayadv, datadv, monadv, alarmon;
  logic [3:0] mode;
  int checks = 0, passed = 0;
  set_mode_ctrl #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn), .alarm_btn(alarm_btn),
    .timeset(timeset), .alarmset(alarmset), .minadv(minadv), .hrsadv(hrsadv),
    .dayadv(dayadv), .datadv(datadv), .monadv(monadv), .alarmon(alarmon), .mode(mode)
  );
  always #5 clk = ~clk;
  int m_state = 0, m_hold = 0, m_idle = 0;
  bit m_alarm = 0, m_pm = 0, m_pal = 0, live = 0;
  logic [4:0] e_stb = 0;
  int field_of [9] = '{0, 1, 2, 3, 4, 5, 1, 2, 3};
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin : model
    int st, nst, f;
    bit me, ae, tmo, go;
    if (rst) begin
      m_state = 0; m_hold = 0; m_idle = 0; m_alarm = 0; m_pm = 0; m_pal = 0;
      e_stb = 0; live = 1;
    end else begin
      me = mode_btn && !m_pm;
      ae = alarm_btn && !m_pal;
      st = m_state;
`ifdef SETMODE_TIMEOUT_EN
      tmo = st != 0 && m_idle >= TMO;
`else
      tmo = 0;
`endif
      go = adv_btn && (m_hold == 0 || m_hold >= HOLD) && !me && !tmo;
      nst = tmo ? 0 : me ? (st + 1) % 9 : st;
      f = field_of[st];
      e_stb = (go && f != 0) ? 5'(1 << (f - 1)) : 5'd0;
      m_hold = (adv_btn && nst == st) ? ((m_hold < 15) ? m_hold + 1 : 15) : 0;
      m_idle = (me || adv_btn || st == 0) ? 0 : m_idle + 1;
      m_alarm ^= ae;
      m_pm = mode_btn;
      m_pal = alarm_btn;
      m_state = nst;
    end
  end
  always @(negedge clk) if (live) begin
    check("model_mode", int'(mode), m_state);
    check("model_timeset", int'(timeset), int'(m_state inside {[1:5]}));
    check("model_alarmset", int'(alarmset), int'(m_state inside {[6:8]}));
    check("model_strobes", int'({monadv, datadv, dayadv, hrsadv, minadv}), int'(e_stb));
    check("model_alarmon", int'(alarmon), int'(m_alarm));
    check("strobe_onehot", int'($countones({monadv, datadv, dayadv, hrsadv, minadv}) <= 1), 1);
  end
  task automatic tick(input bit m = 0, input bit a = 0, input bit al = 0, input bit r = 0);
    @(negedge clk);
    mode_btn = m; adv_btn = a; alarm_btn = al; rst = r;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_mode(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      tick(0);
    end
  endtask
  initial begin
    logic [5:0] pat;
    int n;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("rst_mode", int'(mode), 0);
    check("rst_flags", int'({timeset, alarmset, alarmon, minadv, hrsadv, dayadv, datadv, monadv}), 0);
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      check("seq_mode", int'(mode), i % 9);
      check("seq_timeset", int'(timeset), int'(i >= 1 && i <= 5));
      check("seq_alarmset", int'(alarmset), int'(i >= 6 && i <= 8));
      tick(0);
    end
    pulse_mode(1);
    check("tmin_mode", int'(mode), 1);
    pat = 6'b111001;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick(0, 1);
      check("hold_minadv", int'(minadv), int'(pat[k]));
      check("hold_other", int'({hrsadv, dayadv, datadv, monadv}), 0);
      n += int'(minadv);
    end
    tick(0);
    check("hold_release", int'(minadv), 0);
    check("hold_count", n, 4);
    pulse_mode(3);
    check("tdat_mode", int'(mode), 4);
    tick(1, 1);
    check("collide_mode", int'(mode), 5);
    check("collide_strobes", int'({datadv, monadv}), 0);
    tick(0);
    tick(0, 1);
    check("tmon_first", int'(monadv), 1);
    tick(0, 1);
    check("tmon_wait", int'(monadv), 0);
    for (int k = 0; k < 2; k++) begin
      tick(0, 1, 0, 1);
      check("rst_mid_hold", int'({mode, timeset, alarmset, alarmon, minadv, hrsadv, dayadv, datadv, monadv}), 0);
    end
    tick(0, 1);
    check("after_rst_mode", int'(mode), 0);
    check("after_rst_monadv", int'(monadv), 0);
    tick(0);
    pulse_mode(2);
    check("thrs_mode", int'(mode), 2);
    tick(0, 0, 1);
    check("alarm_on", int'(alarmon), 1);
    check("alarm_hrs", int'(hrsadv), 0);
    tick(0);
    tick(0, 0, 1);
    check("alarm_off", int'(alarmon), 0);
    tick(0);
    tick(0, 0, 1, 1);
    check("alarm_rst", int'(alarmon), 0);
    tick(0, 0, 1);
    check("alarm_held_release", int'(alarmon), 1);
    tick(0);
    tick(1, 0, 1);
    check("alarm_with_mode", int'(alarmon), 0);
    check("mode_with_alarm", int'(mode), 1);
    tick(0);
    pulse_mode(2);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 1);
      n += int'(dayadv);
    end
    tick(0);
    check("day_saturate_count", n, 18);
    tick(0, 0, 0, 1);
    tick(0);
    pulse_mode(6);
    check("amin_mode", int'(mode), 6);
    repeat (100) tick(0);
`ifdef SETMODE_TIMEOUT_EN
    check("idle_mode", int'(mode), 0);
`else
    check("idle_mode", int'(mode), 6);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
